// File: rtl/tqvp_htfab_vga_pkg.sv
// Shared definitions for the baby-VGA framebuffer write path.
// Used by the line FIFO and the tear-free write scheduler.
package tqvp_htfab_vga_pkg;

  localparam int FB_LINES = 16;
  localparam int FB_AW    = 4;
  localparam int FB_DW    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/tqvp_htfab_vga_line_fifo.sv
// Line-write FIFO: storage, pointers and occupancy for queued framebuffer writes.
// With FB_SCHED_COALESCE_EN defined it also offers an address-match port for in-place updates.
module tqvp_htfab_vga_line_fifo
  import tqvp_htfab_vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = FB_AW,
  parameter int DW    = FB_DW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc,
  input  logic                       pop,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
`ifdef FB_SCHED_COALESCE_EN
  input  logic                       upd,
  output logic                       hit,
`endif
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem_r [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

`ifdef FB_SCHED_COALESCE_EN
  logic [PW-1:0] hit_idx_s;
  logic [PW-1:0] scan_idx_s;

  // Newest matching entry wins; the head being popped this cycle is excluded.
  always_comb begin
    hit        = 1'b0;
    hit_idx_s  = {PW{1'b0}};
    scan_idx_s = {PW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx_s = rd_ptr_r + PW'(k);
      if ((CW'(k) < count_r) && !((k == 0) && pop) &&
          (addr_mem_r[scan_idx_s] == push_addr)) begin
        hit       = 1'b1;
        hit_idx_s = scan_idx_s;
      end else begin
        hit       = hit;
        hit_idx_s = hit_idx_s;
      end
    end
  end
`endif

  // Storage, pointer and occupancy update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {AW{1'b0}};
        data_mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (alloc) begin
        addr_mem_r[wr_ptr_r] <= push_addr;
        data_mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r             <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
`ifdef FB_SCHED_COALESCE_EN
      else if (upd) begin
        data_mem_r[hit_idx_s] <= push_data;
      end
`endif
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + CW'(alloc) - CW'(pop);
    end
  end

  assign head_addr = addr_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];
  assign count     = count_r;
  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});

endmodule

// File: rtl/tqvp_htfab_vga_fb_scheduler.sv
// Tear-free framebuffer write scheduler: queues CPU line writes and commits them in vblank or immediately.
// Optional FB_SCHED_COALESCE_EN merges a write into a queued entry for the same line.
module tqvp_htfab_vga_fb_scheduler
  import tqvp_htfab_vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = FB_AW,
  parameter int DW    = FB_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [AW-1:0]          req_addr,
  input  logic [DW-1:0]          req_data,
  output logic                   req_ready,
  input  logic                   vblank,
  input  logic                   immediate,
  input  logic                   ovf_clr,
  output logic                   fb_we,
  output logic [AW-1:0]          fb_addr,
  output logic [DW-1:0]          fb_data,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow,
  output logic                   commit_done
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_t  state_r;
  sched_state_t  state_nxt_s;
  logic          drain_ok_s;
  logic          ready_s;
  logic          alloc_s;
  logic          pop_s;
  logic          ovf_set_s;
  logic          last_pop_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_nxt_s;
  logic [AW-1:0] head_addr_s;
  logic [DW-1:0] head_data_s;
  logic          fb_we_r;
  logic [AW-1:0] fb_addr_r;
  logic [DW-1:0] fb_data_r;
  logic          overflow_r;
  logic          commit_done_r;
`ifdef FB_SCHED_COALESCE_EN
  logic          hit_s;
  logic          upd_s;
`endif

  tqvp_htfab_vga_line_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc     (alloc_s),
    .pop       (pop_s),
    .push_addr (req_addr),
    .push_data (req_data),
`ifdef FB_SCHED_COALESCE_EN
    .upd       (upd_s),
    .hit       (hit_s),
`endif
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Push acceptance, pop decision and post-edge occupancy; a full FIFO never allocates, even while popping
  always_comb begin
    drain_ok_s = immediate || vblank;
`ifdef FB_SCHED_COALESCE_EN
    ready_s    = !full_s || hit_s;
    alloc_s    = req_valid && !full_s && !hit_s;
    upd_s      = req_valid && hit_s;
`else
    ready_s    = !full_s;
    alloc_s    = req_valid && !full_s;
`endif
    ovf_set_s   = req_valid && !ready_s;
    pop_s       = drain_ok_s && !empty_s && (state_r != IDLE);
    count_nxt_s = count_s + CW'(alloc_s) - CW'(pop_s);
    last_pop_s  = pop_s && (count_nxt_s == {CW{1'b0}});
  end

  // Scheduler next-state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_nxt_s == {CW{1'b0}}) begin
          state_nxt_s = IDLE;
        end else if (drain_ok_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      WAIT: begin
        if (count_nxt_s == {CW{1'b0}}) begin
          state_nxt_s = IDLE;
        end else if (drain_ok_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DRAIN: begin
        if (count_nxt_s == {CW{1'b0}}) begin
          state_nxt_s = IDLE;
        end else if (!drain_ok_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Framebuffer port and status registers; address/data hold between writes, overflow set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we_r       <= 1'b0;
      fb_addr_r     <= {AW{1'b0}};
      fb_data_r     <= {DW{1'b0}};
      overflow_r    <= 1'b0;
      commit_done_r <= 1'b0;
    end else begin
      fb_we_r       <= pop_s;
      commit_done_r <= last_pop_s;
      if (pop_s) begin
        fb_addr_r <= head_addr_s;
        fb_data_r <= head_data_s;
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign req_ready   = ready_s;
  assign pending     = count_s;
  assign fb_we       = fb_we_r;
  assign fb_addr     = fb_addr_r;
  assign fb_data     = fb_data_r;
  assign overflow    = overflow_r;
  assign commit_done = commit_done_r;

endmodule

// File: doc/tqvp_htfab_vga_fb_scheduler.md
Name: tqvp_htfab_vga_fb_scheduler

Overview:
- Tear-free write scheduler in front of the 16-line × 32-bit baby-VGA framebuffer write port.
- CPU line writes are queued in a small FIFO and committed to the framebuffer only during vertical blank, or at once in immediate mode.
- Sits between the peripheral register decode and the framebuffer write port.
- Reports occupancy, overflow and end-of-commit to software.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..8.
- AW, 4: line address width (16 lines).
- DW, 32: line data width (one pixel per bit).

Ports:
- clk  input  1  system clock (64 MHz nominal).
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  CPU line-write request.
- req_addr  input  AW  target line.
- req_data  input  DW  line pixels.
- req_ready  output  1  FIFO can accept; equals !full.
- vblank  input  1  high while the timing generator is in vertical blank.
- immediate  input  1  1 = drain regardless of vblank.
- ovf_clr  input  1  clears overflow.
- fb_we  output  1  framebuffer write strobe.
- fb_addr  output  AW  framebuffer write line.
- fb_data  output  DW  framebuffer write data.
- pending  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a push is attempted while full.
- commit_done  output  1  one-cycle pulse when the FIFO empties through a drain.

Behaviour:
- Reset (async): FIFO pointers, count and state cleared; all outputs 0 except req_ready=1. fb_we drops immediately, even mid-drain; queued entries are discarded.
- Push: occurs when req_valid && req_ready; entry {req_addr, req_data} is written at the tail. req_valid while full drops the entry, sets overflow, and leaves the FIFO unchanged.
- No bypass path: a push and a pop in the same cycle are both honoured; count is unchanged.
- A full FIFO does not accept a push even when a pop happens in the same cycle.
- Drain enable: drain_ok = immediate || vblank, sampled on the current cycle.
- State machine:
  - IDLE: FIFO empty. Goes to WAIT when count becomes nonzero.
  - WAIT: FIFO nonempty, drain_ok=0. Goes to DRAIN when drain_ok=1.
  - DRAIN: pops one entry per cycle while drain_ok=1 and FIFO nonempty.
    - drain_ok falls with entries left → WAIT; remaining entries are held to the next vblank.
    - FIFO empties → IDLE, and commit_done pulses in the cycle fb_we carries the last entry.
- Output timing: fb_we/fb_addr/fb_data are registered. The popped head appears with fb_we=1 in the cycle after the pop decision (latency 1). fb_addr/fb_data hold their last value when fb_we=0.
- Ordering: strictly FIFO. Two writes to the same line commit in order; the last one wins.
- Pointers: wrap modulo DEPTH. count is in 0..DEPTH.
- overflow: set by a dropped push; cleared by ovf_clr. When set and clear occur in the same cycle, set wins.
- pending: reflects count after the current clock edge, no extra delay.

Optional Feature:
- Macro: FB_SCHED_COALESCE_EN.
- Defined:
  - A push whose req_addr matches a queued entry overwrites that entry's data in place. Count and order are unchanged.
  - An entry being popped in the same cycle is excluded from the match; that push allocates a new entry normally.
  - A coalescing push is accepted even when the FIFO is full, so req_ready = !full || addr_hit. It does not set overflow.
  - With multiple matches, the newest entry is updated.
- Undefined: every accepted push allocates a new entry; the address-compare logic is absent.

Decomposition:
- Shared package tqvp_htfab_vga_pkg:
  - FB_LINES=16, FB_AW=4, FB_DW=32.
  - State enum sched_state_t {IDLE, WAIT, DRAIN}.
- Sub-module tqvp_htfab_vga_line_fifo: storage, pointers, count, full/empty, plus the coalesce match port under the macro.
- Top level: state machine, overflow and commit_done logic, output registers.

Test Plan:
- Reset, then push lines 3 (0xA5A5A5A5) and 7 (0x0F0F0F0F) with vblank=0, immediate=0 → pending=2, fb_we stays 0. Raise vblank → fb_we on 2 consecutive cycles with addr 3 then 7 and matching data; commit_done pulses with the second write; pending=0.
- Push 4 entries → req_ready=0. Fifth push (line 9) → overflow=1, pending=4, line 9 never written. Pulse ovf_clr → overflow=0.
- 3 entries queued, vblank high for exactly 2 cycles → exactly 2 writes. Third write occurs only at the next vblank; no commit_done until then.
- immediate=1 with vblank=0, push line 5 (0x12345678) → fb_we=1, addr 5 on the cycle after the push is visible at the head; commit_done=1 in that cycle.
- Assert rst_n low mid-drain with 2 entries left → fb_we=0 with no clock edge, pending=0. After release, raising vblank produces no writes.
- With FB_SCHED_COALESCE_EN defined, push line 2 (0x1) then line 2 (0x2) → pending=1; drain writes line 2 = 0x2 once. With the macro undefined → pending=2, two writes.
